axi_bw_allocator: RTL
=====================

AXI_BW_ALLOCATOR -- requirements
Module: axi_BW_allocator

Interface
REQ-001: Parameter N_INIT_PORT, default 8: number of write-response sources (master-side ports) merged onto one slave port; legal range 1..16.
REQ-002: Parameter AXI_ID, default 6: width of BID on every port; the ID is passed through unmodified.
REQ-003: Parameter AXI_USER, default 6: width of BUSER on every port.
REQ-004: clk  input  1  block clock; single clock domain.
REQ-005: rst  input  1  reset, synchronous, active-high.
REQ-006: bid_i  input  [N_INIT_PORT-1:0][AXI_ID-1:0]  per-source response ID.
REQ-007: bresp_i  input  [N_INIT_PORT-1:0][1:0]  per-source response code.
REQ-008: buser_i  input  [N_INIT_PORT-1:0][AXI_USER-1:0]  per-source user bits.
REQ-009: bvalid_i  input  N_INIT_PORT  per-source valid, already routed to this slave port by the backward decoder.
REQ-010: bready_o  output  N_INIT_PORT  per-source ready.
REQ-011: bid_o / bresp_o / buser_o  output  AXI_ID / 2 / AXI_USER  merged response toward the slave port.
REQ-012: bvalid_o  output  1  merged valid.
REQ-013: bready_i  input  1  slave-port ready.

Function
REQ-014: The block SHALL contain one output register stage (valid_q plus payload), which drives bid_o, bresp_o, buser_o and bvalid_o directly from flops.
REQ-015: accept = !valid_q || bready_i; the stage SHALL load a new beat in the cycle when accept=1 and at least one bvalid_i bit is high.
REQ-016: Latency SHALL be exactly one cycle from an input handshake to bvalid_o; sustained throughput SHALL be one beat per cycle.
REQ-017: Winner selection: round-robin; the winner is the first asserted bvalid_i index at or after pointer rr_q, searching upward modulo N_INIT_PORT.
REQ-018: bready_o SHALL be one-hot or zero: bready_o[k]=1 iff accept=1 and k is the winner; no bready_o bit is high when no source is valid.
REQ-019: After each input handshake on port k, rr_q SHALL become k+1; it wraps from N_INIT_PORT-1 to 0, and the wrap is correct for non-power-of-two N_INIT_PORT.
REQ-020: rr_q SHALL remain unchanged in cycles without an input handshake.
REQ-021: While bvalid_o=1 and bready_i=0, the output payload and bvalid_o SHALL stay stable, and all bready_o bits SHALL be 0.
REQ-022: Simultaneous output drain and input fill (valid_q=1, bready_i=1, request present) SHALL load the new beat in the same cycle with no bubble.
REQ-023: When the output drains (bready_i=1) with no request present, valid_q SHALL clear.
REQ-024: bready_o SHALL depend combinationally on bvalid_i, bready_i and state only; bvalid_o SHALL have no combinational path from any input.
REQ-025: Payload fields SHALL be copied bit-exact; the block SHALL not alter or decode BID, BRESP or BUSER.
REQ-026: With N_INIT_PORT=1, the block SHALL degenerate to a one-stage register slice, and rr_q SHALL stay 0.

Reset
REQ-027: When rst=1 at a clk edge: valid_q=0, rr_q=0, and the payload registers are cleared to 0.
REQ-028: While rst=1, bvalid_o=0 and all bready_o bits SHALL be 0, and no handshake is taken.
REQ-029: A beat held in the output stage when reset is asserted SHALL be discarded.

Structure
REQ-030: Default widths and the BRESP encodings (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) SHALL reside in the shared package axi_node_pkg.
REQ-031: Round-robin selection SHALL be one sub-module, axi_BW_rr_arb (inputs: req vector, rr_q; outputs: one-hot grant, grant index), reusable by the read-response allocator.
REQ-032: The pointer and output register SHALL reside in axi_BW_allocator.

Verification
REQ-033: N=8, only port 3 valid (bid=0x15, bresp=00), bready_i=1 -> bready_o=0x08 in cycle 0; bvalid_o=1 with bid_o=0x15 in cycle 1; rr_q=4.
REQ-034: All 8 ports valid continuously, bready_i=1 -> grant order 0,1,...,7,0 with one beat per cycle and no bubbles.
REQ-035: Output full, bready_i=0 for 5 cycles, ports 2 and 6 valid -> bready_o=0 and bid_o stable throughout; bready_i=1 -> port 2 is granted, then port 6.
REQ-036: N=5, rr_q=4, ports 0 and 4 valid -> port 4 is granted, rr_q wraps to 0, and port 0 is granted next.
REQ-037: Beat in the output stage, rst pulsed for 1 cycle -> bvalid_o=0 in the next cycle; rr_q=0; the beat is lost and no bready_o pulse occurs.
REQ-038: Random valid/ready traffic for 10k cycles -> scoreboard shows a per-port in-order, loss-free, bit-exact payload; no port waits more than N_INIT_PORT grants.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: default port counts/widths, BRESP codes and
// the index-width helper used by the response allocators and arbiters.
package axi_node_pkg;

    localparam int N_INIT_PORT_DEF = 8;
    localparam int AXI_ID_DEF      = 6;
    localparam int AXI_USER_DEF    = 6;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_e;

    // A single-port node still needs a 1-bit index/pointer field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_bw_rr_arb.sv
// Round-robin arbiter: grants the first asserted request at or after the
// pointer, searching upward modulo N. Shared by the B and R allocators.
module axi_bw_rr_arb
    import axi_node_pkg::*;
#(
    parameter int N     = N_INIT_PORT_DEF,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_rr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    int               w_pos;
    logic [IDX_W-1:0] w_sel;
    logic             w_found;

    // Explicit subtract-wrap keeps the search correct for non-power-of-two N.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_sel   = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = int'(i_rr) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_sel = IDX_W'(w_pos);
            if (!w_found && i_req[w_sel]) begin
                w_found        = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end

endmodule

// File: rtl/axi_bw_allocator.sv
// Write-response allocator: merges N master-side B channels onto one slave
// port through a round-robin arbiter and a single registered output stage.
module axi_bw_allocator
    import axi_node_pkg::*;
#(
    parameter int N_INIT_PORT = N_INIT_PORT_DEF,
    parameter int AXI_ID      = AXI_ID_DEF,
    parameter int AXI_USER    = AXI_USER_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_INIT_PORT-1:0][AXI_ID-1:0]     bid_i,
    input  logic [N_INIT_PORT-1:0][1:0]            bresp_i,
    input  logic [N_INIT_PORT-1:0][AXI_USER-1:0]   buser_i,
    input  logic [N_INIT_PORT-1:0]                 bvalid_i,
    output logic [N_INIT_PORT-1:0]                 bready_o,
    output logic [AXI_ID-1:0]                      bid_o,
    output logic [1:0]                             bresp_o,
    output logic [AXI_USER-1:0]                    buser_o,
    output logic                                   bvalid_o,
    input  logic                                   bready_i
);

    localparam int IDX_W = idx_width(N_INIT_PORT);

    logic                   r_valid;
    logic [IDX_W-1:0]       r_rr;
    logic [AXI_ID-1:0]      r_bid;
    logic [1:0]             r_bresp;
    logic [AXI_USER-1:0]    r_buser;

    logic                   w_accept;
    logic                   w_take;
    logic [N_INIT_PORT-1:0] w_grant;
    logic [IDX_W-1:0]       w_idx;
    logic [IDX_W-1:0]       w_rr_next;

    axi_bw_rr_arb #(
        .N     (N_INIT_PORT),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .i_req   (bvalid_i),
        .i_rr    (r_rr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_accept  = !r_valid || bready_i;
    assign w_take    = w_accept && (|bvalid_i) && !rst;
    // Ready is gated by reset so no source sees a handshake that gets dropped.
    assign bready_o  = (w_accept && !rst) ? w_grant : '0;
    assign w_rr_next = (w_idx == IDX_W'(N_INIT_PORT - 1)) ? '0 : w_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rr    <= '0;
            r_bid   <= '0;
            r_bresp <= '0;
            r_buser <= '0;
        end else if (w_take) begin
            r_valid <= 1'b1;
            r_rr    <= w_rr_next;
            r_bid   <= bid_i[w_idx];
            r_bresp <= bresp_i[w_idx];
            r_buser <= buser_i[w_idx];
        end else if (bready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign bvalid_o = r_valid;
    assign bid_o    = r_bid;
    assign bresp_o  = r_bresp;
    assign buser_o  = r_buser;

endmodule
